// File: rtl/timer_pkg.sv
// Shared definitions for the up_timer block: FSM state encoding and board-clock tick rate.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    // 100 MHz board clock -> one count per second
    localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

endpackage : timer_pkg

// File: rtl/tick_gen.sv
// Clock-enable prescaler: asserts tick for one cycle every TICK_DIV enabled cycles.
module tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick      = en && w_at_last;

    // Frozen while en is low so a pause keeps the partial period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule : tick_gen

// File: rtl/up_timer.sv
// Count-up elapsed-time counter: latches a target on start, counts at the prescaled
// tick rate and flags done when the count reaches the target.
module up_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             done_pulse
);

    timer_state_t     r_state;
    timer_state_t     w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] r_target_q;
    logic [WIDTH-1:0] w_target_next;
    logic             r_running;
    logic             r_done;
    logic             r_done_pulse;
    logic             w_done_pulse_next;
    logic             w_tick;
    logic             w_active;
    logic             w_tick_clr;

    // A PAUSE cycle with enable high already counts toward the period, so no enabled cycle is lost
    assign w_active   = enable && !clear && !start
                        && ((r_state == ST_RUN) || (r_state == ST_PAUSE));
    assign w_tick_clr = clear || start;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (w_tick_clr),
        .en    (w_active),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_target_q   <= '0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_target_q   <= w_target_next;
            r_running    <= (w_state_next == ST_RUN);
            r_done       <= (w_state_next == ST_DONE);
            r_done_pulse <= w_done_pulse_next;
        end
    end

    // Next-state logic, priority clear > start > state behaviour
    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_target_next     = r_target_q;
        w_done_pulse_next = 1'b0;

        if (clear) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
        end else if (start) begin
            w_target_next     = target;
            w_count_next      = '0;
            w_state_next      = (target != '0) ? ST_RUN : ST_DONE;
            w_done_pulse_next = (target == '0);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_count_next = '0;
                end
                ST_RUN, ST_PAUSE: begin
                    if (!enable) begin
                        w_state_next = ST_PAUSE;
                    end else begin
                        w_state_next = ST_RUN;
                        if (w_tick) begin
                            if (r_count == r_target_q - WIDTH'(1)) begin
                                w_count_next      = r_target_q;
                                w_state_next      = ST_DONE;
                                w_done_pulse_next = 1'b1;
                            end else begin
                                w_count_next = r_count + WIDTH'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    w_count_next = r_target_q;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign count      = r_count;
    assign running    = r_running;
    assign done       = r_done;
    assign done_pulse = r_done_pulse;

endmodule : up_timer

// File: tb/tb_up_timer.sv
// Directed bench for up_timer with TICK_DIV=4, WIDTH=8; inputs change and outputs
// are sampled on the falling clock edge.
module tb_up_timer;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned TICK_DIV = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done;
    logic             done_pulse;

    int n_tests;
    int n_fail;

    up_timer #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .enable     (enable),
        .clear      (clear),
        .target     (target),
        .count      (count),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one cycle; returns at the falling edge right after the start edge
    task automatic do_start(input logic [WIDTH-1:0] tgt);
        target = tgt;
        start  = 1'b1;
        cyc(1);
        start  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        target  = '0;

        // Reset values
        cyc(2);
        check("rst_count", 32'(count), 0);
        check("rst_running", 32'(running), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pulse", 32'(done_pulse), 0);
        reset = 1'b0;
        cyc(1);

        // target=5: step every 4 clocks, done_pulse 20 clocks after start; target change ignored
        enable = 1'b1;
        do_start(8'd5);
        check("run_count0", 32'(count), 0);
        check("run_running", 32'(running), 1);
        for (int j = 1; j <= 24; j++) begin
            cyc(1);
            exp_cnt = (j / 4 > 5) ? 5 : j / 4;
            check("run_count", 32'(count), 32'(exp_cnt));
            check("run_pulse", 32'(done_pulse), (j == 20) ? 1 : 0);
            check("run_done", 32'(done), (j >= 20) ? 1 : 0);
            if (j == 6) target = 8'd1;
        end
        check("done_running", 32'(running), 0);
        do_clear();
        check("clr_count", 32'(count), 0);
        check("clr_done", 32'(done), 0);

        // Pause at prescaler=2, count=3 for 7 cycles
        do_start(8'd10);
        cyc(14);
        check("pause_pre_count", 32'(count), 3);
        enable = 1'b0;
        for (int j = 0; j < 7; j++) begin
            cyc(1);
            check("pause_running", 32'(running), 0);
            check("pause_count", 32'(count), 3);
        end
        enable = 1'b1;
        cyc(1);
        check("resume_count_hold", 32'(count), 3);
        check("resume_running", 32'(running), 1);
        cyc(1);
        check("resume_count_inc", 32'(count), 4);

        // Asynchronous reset mid-run (count=3)
        do_start(8'd10);
        cyc(12);
        check("prerst_count", 32'(count), 3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_running", 32'(running), 0);
        check("arst_done", 32'(done), 0);
        cyc(1);
        reset = 1'b0;
        cyc(8);
        check("arst_idle_count", 32'(count), 0);
        check("arst_idle_running", 32'(running), 0);

        // target=0 goes straight to DONE
        do_start(8'd0);
        check("t0_done", 32'(done), 1);
        check("t0_pulse", 32'(done_pulse), 1);
        check("t0_count", 32'(count), 0);
        check("t0_running", 32'(running), 0);
        cyc(1);
        check("t0_pulse_once", 32'(done_pulse), 0);
        check("t0_done_hold", 32'(done), 1);

        // target=255 reaches all-ones without wrap
        do_start(8'd255);
        cyc(255 * 4 - 1);
        check("t255_pre_count", 32'(count), 254);
        check("t255_pre_done", 32'(done), 0);
        cyc(1);
        check("t255_count", 32'(count), 255);
        check("t255_pulse", 32'(done_pulse), 1);
        cyc(10);
        check("t255_hold", 32'(count), 255);
        check("t255_done", 32'(done), 1);

        // Simultaneous clear and start in RUN: clear wins
        do_start(8'd10);
        cyc(5);
        check("cs_pre_count", 32'(count), 1);
        clear  = 1'b1;
        start  = 1'b1;
        target = 8'd3;
        cyc(1);
        clear  = 1'b0;
        start  = 1'b0;
        check("cs_count", 32'(count), 0);
        check("cs_running", 32'(running), 0);
        cyc(6);
        check("cs_idle_count", 32'(count), 0);
        check("cs_idle_done", 32'(done), 0);

        // Restart from PAUSE with target=2
        do_start(8'd10);
        cyc(2);
        enable = 1'b0;
        cyc(1);
        check("rp_paused", 32'(running), 0);
        enable = 1'b1;
        do_start(8'd2);
        check("rp_running", 32'(running), 1);
        check("rp_count", 32'(count), 0);
        cyc(7);
        check("rp_pre_pulse", 32'(done_pulse), 0);
        check("rp_pre_count", 32'(count), 1);
        cyc(1);
        check("rp_pulse", 32'(done_pulse), 1);
        check("rp_count_done", 32'(count), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_up_timer
